// File: rtl/dat_tx_ctrl.sv
// rtl/dat_tx_ctrl.sv - SD DAT write-path sequencer (1-bit bus): block framing, CRC16, status token, busy wait
module dat_tx_ctrl #(
    parameter int BLOCK_WORDS  = 128,
    parameter int BUSY_TIMEOUT = 65535,
    parameter int STATUS_WAIT  = 8
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_blocks,
    input  logic [31:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd,
    output logic        ser_enable,
    output logic [31:0] ser_word,
    output logic        ser_send,
    input  logic        ser_bit,
    input  logic        ser_complete,
    output logic        dat_out,
    output logic        dat_oe,
    input  logic        dat_in,
    output logic        busy,
    output logic        done,
    output logic        crc_err,
    output logic        timeout_err,
    output logic        underrun_err
);
    localparam int              WCW         = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WCW-1:0]  LAST_WORD   = WCW'(BLOCK_WORDS - 1);
    localparam logic [15:0]     STATUS_LAST = 16'(STATUS_WAIT - 1);
    localparam logic [15:0]     BUSY_LAST   = 16'(BUSY_TIMEOUT - 1);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PRELOAD = 4'd1;
    localparam logic [3:0] ST_START   = 4'd2;
    localparam logic [3:0] ST_DATA    = 4'd3;
    localparam logic [3:0] ST_CRC     = 4'd4;
    localparam logic [3:0] ST_END     = 4'd5;
    localparam logic [3:0] ST_TURN    = 4'd6;
    localparam logic [3:0] ST_STATUS  = 4'd7;
    localparam logic [3:0] ST_TOKEN   = 4'd8;
    localparam logic [3:0] ST_BUSY    = 4'd9;
    localparam logic [3:0] ST_ABORT   = 4'd10;
    localparam logic [3:0] ST_DONE    = 4'd11;

    logic [3:0]     state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [7:0]     blk_cnt_q, blk_cnt_d;
    logic [15:0]    crc_q, crc_d;
    logic [1:0]     tok_q, tok_d;
    logic           crc_err_q, crc_err_d;
    logic           timeout_err_q, timeout_err_d;
    logic           underrun_err_q, underrun_err_d;
    logic           zero_done_q, zero_done_d;
    logic           load;

    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        blk_cnt_d      = blk_cnt_q;
        crc_d          = crc_q;
        tok_d          = tok_q;
        crc_err_d      = crc_err_q;
        timeout_err_d  = timeout_err_q;
        underrun_err_d = underrun_err_q;
        zero_done_d    = 1'b0;
        load           = 1'b0;
        // Shared phase counter: saturates, and restarts from zero on every state change
        cnt_d          = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    crc_err_d      = 1'b0;
                    timeout_err_d  = 1'b0;
                    underrun_err_d = 1'b0;
                    blk_cnt_d      = num_blocks;
                    if (num_blocks == 8'd0) zero_done_d = 1'b1;
                    else                    state_d     = ST_PRELOAD;
                end
            end
            ST_PRELOAD: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    word_cnt_d = '0;
                    crc_d      = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: state_d = ST_DATA;
            ST_DATA: begin
                crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ ser_bit) ? 16'h1021 : 16'h0000);
                if (ser_complete) begin
                    if (word_cnt_q < LAST_WORD) begin
                        if (!fifo_empty) begin
                            load       = 1'b1;
                            word_cnt_d = word_cnt_q + WCW'(1);
                        end else begin
                            underrun_err_d = 1'b1;
                            state_d        = ST_ABORT;
                        end
                    end else begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                crc_d = {crc_q[14:0], 1'b0};
                if (cnt_q == 16'd15) state_d = ST_END;
            end
            ST_END: state_d = ST_TURN;
            ST_TURN: begin
                if (cnt_q == 16'd1) state_d = ST_STATUS;
            end
            ST_STATUS: begin
                if (!dat_in) begin
                    state_d = ST_TOKEN;
                end else if (cnt_q == STATUS_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_ABORT;
                end
            end
            ST_TOKEN: begin
                tok_d = {tok_q[0], dat_in};
                if (cnt_q == 16'd2) begin
                    if ({tok_q, dat_in} == 3'b010) begin
                        state_d = ST_BUSY;
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = ST_ABORT;
                    end
                end
            end
            ST_BUSY: begin
                if (dat_in) begin
                    blk_cnt_d = blk_cnt_q - 8'd1;
                    state_d   = (blk_cnt_q == 8'd1) ? ST_DONE : ST_PRELOAD;
                end else if (cnt_q == BUSY_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_ABORT;
                end
            end
            ST_ABORT, ST_DONE: state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= '0;
            cnt_q          <= '0;
            blk_cnt_q      <= '0;
            crc_q          <= '0;
            tok_q          <= '0;
            crc_err_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
            underrun_err_q <= 1'b0;
            zero_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            cnt_q          <= cnt_d;
            blk_cnt_q      <= blk_cnt_d;
            crc_q          <= crc_d;
            tok_q          <= tok_d;
            crc_err_q      <= crc_err_d;
            timeout_err_q  <= timeout_err_d;
            underrun_err_q <= underrun_err_d;
            zero_done_q    <= zero_done_d;
        end
    end

    always_comb begin
        dat_oe  = 1'b0;
        dat_out = 1'b1;
        case (state_q)
            ST_START: begin dat_oe = 1'b1; dat_out = 1'b0;      end
            ST_DATA:  begin dat_oe = 1'b1; dat_out = ser_bit;   end
            ST_CRC:   begin dat_oe = 1'b1; dat_out = crc_q[15]; end
            ST_END:   begin dat_oe = 1'b1; dat_out = 1'b1;      end
            default:  begin dat_oe = 1'b0; dat_out = 1'b1;      end
        endcase
    end

    assign fifo_rd      = load;
    assign ser_enable   = load;
    assign ser_word     = fifo_data;
    assign ser_send     = (state_q == ST_DATA);
    assign busy         = (state_q != ST_IDLE);
    assign done         = zero_done_q | (state_q == ST_ABORT) | (state_q == ST_DONE);
    assign crc_err      = crc_err_q;
    assign timeout_err  = timeout_err_q;
    assign underrun_err = underrun_err_q;
endmodule
